// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU and its arbiter.
//   exe_cmd encodings (CMD_MOV..CMD_MVN), NZCV bit indices, arbiter FSM
//   state encoding, and a legality helper for exe_cmd.
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam int SR_N = 3;
  localparam int SR_C = 2;
  localparam int SR_Z = 1;
  localparam int SR_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  // Legal encodings form the contiguous range MOV..MVN.
  function automatic logic cmd_legal(input logic [3:0] cmd);
    return (cmd >= CMD_MOV) && (cmd <= CMD_MVN);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational execute-stage ALU.
//   first, second : operands A / B
//   exe_cmd       : operation select (see alu_pkg)
//   sr            : current NZCV register (carry-in for ADC/SBC, pass-through)
//   alu_result    : operation result, modulo 2^DATA_W
//   status        : NZCV produced by the operation
// SUB/SBC use the inverted-borrow convention: C=1 means no borrow.
// Logical ops and moves set N/Z and keep C/V from sr.
// Illegal commands give result 0 and status equal to sr.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int SR_W   = 4
) (
  input  logic [DATA_W-1:0] first,
  input  logic [DATA_W-1:0] second,
  input  logic [CMD_W-1:0]  exe_cmd,
  input  logic [SR_W-1:0]   sr,
  output logic [DATA_W-1:0] alu_result,
  output logic [SR_W-1:0]   status
);

  logic [DATA_W-1:0]        addend;
  logic                     cin;
  logic                     arith;
  logic [DATA_W:0]          sum;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] r_s;

  always_comb begin
    addend     = '0;
    cin        = 1'b0;
    arith      = 1'b0;
    alu_result = '0;
    status     = sr;
    sum        = '0;
    a_s        = '0;
    b_s        = '0;
    r_s        = '0;

    // Subtraction is A + ~B + carry, so one adder serves all four ops.
    case (exe_cmd)
      CMD_ADD: begin addend = second;  arith = 1'b1; end
      CMD_ADC: begin addend = second;  cin = sr[SR_C]; arith = 1'b1; end
      CMD_SUB: begin addend = ~second; cin = 1'b1;     arith = 1'b1; end
      CMD_SBC: begin addend = ~second; cin = sr[SR_C]; arith = 1'b1; end
      default: ;
    endcase

    sum = {1'b0, first} + {1'b0, addend} + {{DATA_W{1'b0}}, cin};

    case (exe_cmd)
      CMD_MOV: alu_result = second;
      CMD_MVN: alu_result = ~second;
      CMD_AND: alu_result = first & second;
      CMD_ORR: alu_result = first | second;
      CMD_EOR: alu_result = first ^ second;
      default: if (arith) alu_result = sum[DATA_W-1:0];
    endcase

    if (cmd_legal(exe_cmd)) begin
      status[SR_N] = alu_result[DATA_W-1];
      status[SR_Z] = (alu_result == '0);
      if (arith) begin
        a_s          = first;
        b_s          = addend;
        r_s          = alu_result;
        status[SR_C] = sum[DATA_W];
        // Signed overflow: same-sign inputs producing a result of the other sign.
        status[SR_V] = ((a_s < 0) == (b_s < 0)) && ((r_s < 0) != (a_s < 0));
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between port 0 (pipeline EX) and port 1
// (address-gen/debug). Requests are accepted only in IDLE; the op runs in EXEC;
// the result is offered in RESP until the owning port takes it.
// The module owns the architectural NZCV register sr.
//   clk, rst (async, active-low), flush (aborts the in-flight op)
//   reqN_valid/ready/first/second/cmd/s : request channel, N=0,1
//   rspN_valid/ready                    : response handshake, N=0,1
//   rsp_result, rsp_status              : result and flags of the owning op
//   sr                                  : architectural status register
//   busy                                : FSM not in IDLE
// Build option: ALU_ARB_ROUND_ROBIN_EN -> a contest goes to the port that did
// not win last time; otherwise port 0 always wins a contest.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int SR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_first,
  input  logic [DATA_W-1:0] req0_second,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic              req0_s,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_first,
  input  logic [DATA_W-1:0] req1_second,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic              req1_s,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [SR_W-1:0]   rsp_status,
  output logic [SR_W-1:0]   sr,
  output logic              busy
);

  arb_state_e        state, state_nxt;
  logic              owner;
  logic              last_grant;
  logic              grant_vld;
  logic              grant_port;
  logic              accept;
  logic [DATA_W-1:0] first_p0;
  logic [DATA_W-1:0] second_p0;
  logic [CMD_W-1:0]  cmd_p0;
  logic              s_p0;
  logic [DATA_W-1:0] alu_result;
  logic [SR_W-1:0]   alu_status;

  always_comb begin
    grant_vld  = 1'b0;
    grant_port = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      grant_port = ~last_grant;
`else
      grant_port = 1'b0;
`endif
    end else if (req0_valid) begin
      grant_vld = 1'b1;
    end else if (req1_valid) begin
      grant_vld  = 1'b1;
      grant_port = 1'b1;
    end
  end

  // flush in IDLE suppresses acceptance for that cycle.
  assign accept = (state == IDLE) && !flush && grant_vld;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req0_ready = accept && !grant_port;
        req1_ready = accept && grant_port;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = flush ? IDLE : RESP;
      RESP: begin
        // A flushed response is withdrawn so it cannot be taken that cycle.
        rsp0_valid = !flush && !owner;
        rsp1_valid = !flush && owner;
        if (flush || (owner ? rsp1_ready : rsp0_ready)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: operand capture at accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      first_p0  <= grant_port ? req1_first  : req0_first;
      second_p0 <= grant_port ? req1_second : req0_second;
      cmd_p0    <= grant_port ? req1_cmd    : req0_cmd;
      s_p0      <= grant_port ? req1_s      : req0_s;
    end
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W),
    .CMD_W  (CMD_W),
    .SR_W   (SR_W)
  ) u_alu (
    .first      (first_p0),
    .second     (second_p0),
    .exe_cmd    (cmd_p0),
    .sr         (sr),
    .alu_result (alu_result),
    .status     (alu_status)
  );

  // ---- stage p1: result register and status update at end of EXEC ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant_port;
        last_grant <= grant_port;
      end
      if (state == EXEC && !flush) begin
        rsp_result <= alu_result;
        rsp_status <= alu_status;
        if (s_p0 && cmd_legal(cmd_p0)) sr <= alu_status;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  typedef struct {
    bit          port;
    logic [31:0] res;
    logic [3:0]  st;
  } exp_t;

  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  logic        clk, rst, flush;
  logic        req0_valid, req0_ready, req0_s, req1_valid, req1_ready, req1_s;
  logic [31:0] req0_first, req0_second, req1_first, req1_second;
  logic [3:0]  req0_cmd, req1_cmd;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_status, sr;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q[$];
  logic [3:0]  m_sr;
  int          m_last;
  logic [31:0] op_a[2], op_b[2];
  logic [3:0]  op_c[2];
  logic        op_s[2];

  alu_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_first(req0_first),
    .req0_second(req0_second), .req0_cmd(req0_cmd), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_first(req1_first),
    .req1_second(req1_second), .req1_cmd(req1_cmd), .req1_s(req1_s),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status), .sr(sr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: NZCV semantics from plain integer arithmetic.
  function automatic void model_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] srin, output logic legal,
                                   output logic [31:0] res, output logic [3:0] st);
    longint ua, ub, sa, sb, ur, sres;
    int     k;
    bit     c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = srin[2];
    v = srin[0];
    legal = 1'b1;
    res = '0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      4'd2, 4'd3: begin
        k = (cmd == 4'd3) ? int'(srin[2]) : 0;
        ur = ua + ub + k;
        res = ur[31:0];
        c = (ur > 64'sh0_FFFF_FFFF);
        sres = sa + sb + k;
        v = (sres > SMAX) || (sres < SMIN);
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd5) ? int'(!srin[2]) : 0;
        ur = ua - ub - k;
        res = ur[31:0];
        c = (ua >= ub + k);
        sres = sa - sb - k;
        v = (sres > SMAX) || (sres < SMIN);
      end
      default: legal = 1'b0;
    endcase
    st = legal ? {res[31], c, (res == 32'd0), v} : srin;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Response monitor: pops the scoreboard whenever a response handshake is set up.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst === 1'b1 && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got response with empty scoreboard");
      end else begin
        e = q.pop_front();
        chk("rsp_onehot", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
        chk("rsp_port", {63'd0, rsp1_valid}, {63'd0, e.port});
        chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
        chk("rsp_status", {60'd0, rsp_status}, {60'd0, e.st});
      end
    end
  end

  // fmode: 0 normal, 1 flush in EXEC, 2 flush in RESP. hold: cycles with owner rsp_ready=0.
  task automatic issue(input bit [1:0] mask, input int fmode, input int hold);
    int          g;
    logic        legal;
    logic [31:0] res;
    logic [3:0]  st;
    exp_t        e;
    if (mask == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      g = (m_last == 0) ? 1 : 0;
`else
      g = 0;
`endif
    end else begin
      g = mask[1] ? 1 : 0;
    end
    req0_valid = mask[0]; req1_valid = mask[1];
    req0_first = op_a[0]; req0_second = op_b[0]; req0_cmd = op_c[0]; req0_s = op_s[0];
    req1_first = op_a[1]; req1_second = op_b[1]; req1_cmd = op_c[1]; req1_s = op_s[1];
    #1;
    chk("req_ready_grant", {62'd0, req1_ready, req0_ready}, (g == 1) ? 64'd2 : 64'd1);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = g;
    model_op(op_c[g], op_a[g], op_b[g], m_sr, legal, res, st);
    if (g == 0) begin
      rsp0_ready = (hold == 0) && (fmode != 2);
      rsp1_ready = 1'($urandom_range(0, 1));
    end else begin
      rsp1_ready = (hold == 0) && (fmode != 2);
      rsp0_ready = 1'($urandom_range(0, 1));
    end
    if (fmode == 1) flush = 1'b1;
    #1;
    chk("busy_exec", {63'd0, busy}, 64'd1);
    chk("rsp_valid_exec", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    @(negedge clk);
    if (fmode == 1) begin
      flush = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      chk("flush_exec_busy", {63'd0, busy}, 64'd0);
      chk("flush_exec_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
      chk("flush_exec_sr", {60'd0, sr}, {60'd0, m_sr});
      return;
    end
    if (op_s[g] && legal) m_sr = st;
    if (fmode == 2) begin
      flush = 1'b1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      chk("flush_resp_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
      chk("flush_resp_sr", {60'd0, sr}, {60'd0, m_sr});
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_resp_busy", {63'd0, busy}, 64'd0);
      chk("flush_resp_gone", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
      return;
    end
    e.port = 1'(g); e.res = res; e.st = st;
    q.push_back(e);
    #1;
    chk("rsp_valid_latency", {62'd0, rsp1_valid, rsp0_valid}, (g == 1) ? 64'd2 : 64'd1);
    chk("sr_after_exec", {60'd0, sr}, {60'd0, m_sr});
    chk("req_ready_resp", {62'd0, req1_ready, req0_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == hold - 1) begin
        if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      end
      #1;
      chk("hold_valid", {62'd0, rsp1_valid, rsp0_valid}, (g == 1) ? 64'd2 : 64'd1);
      chk("hold_result", {32'd0, rsp_result}, {32'd0, res});
      chk("hold_req_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    end
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("busy_done", {63'd0, busy}, 64'd0);
    chk("rsp_valid_done", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
  endtask

  task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic s);
    op_a[p] = a; op_b[p] = b; op_c[p] = c; op_s[p] = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [1:0] mask;
    int       r, fmode, hold;
    rst = 1'b0; flush = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_s = 1'b0; req1_s = 1'b0;
    req0_first = '0; req0_second = '0; req0_cmd = '0;
    req1_first = '0; req1_second = '0; req1_cmd = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    m_sr = 4'd0; m_last = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_sr", {60'd0, sr}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_result", {32'd0, rsp_result}, 64'd0);
    chk("reset_status", {60'd0, rsp_status}, 64'd0);
    chk("reset_valid", {60'd0, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Contest: both ports valid for four ops.
    for (int i = 0; i < 4; i++) begin
      set_op(0, 32'(100 + i), 32'd1, 4'b0010, 1'b0);
      set_op(1, 32'(200 + i), 32'd2, 4'b0010, 1'b0);
      issue(2'b11, 0, 0);
    end

    // ADDS 5+7.
    set_op(0, 32'd5, 32'd7, 4'b0010, 1'b1);
    issue(2'b01, 0, 0);
    chk("adds_5_7_sr", {60'd0, sr}, 64'd0);

    // ADDS carry out, then ADC using it without S.
    set_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 1'b1);
    issue(2'b01, 0, 0);
    chk("adds_carry_sr", {60'd0, sr}, 64'h6);
    set_op(0, 32'd1, 32'd1, 4'b0011, 1'b0);
    issue(2'b01, 0, 0);
    chk("adc_no_s_sr", {60'd0, sr}, 64'h6);

    // Port 1 response held off for five cycles.
    set_op(1, 32'h0F0F_0000, 32'h0000_00F0, 4'b0111, 1'b0);
    issue(2'b10, 0, 5);

    // SUBS flushed in EXEC, then a fresh op.
    set_op(0, 32'd3, 32'd3, 4'b0100, 1'b1);
    issue(2'b01, 1, 0);
    chk("flush_subs_sr", {60'd0, sr}, 64'h6);
    set_op(0, 32'd9, 32'd42, 4'b0001, 1'b0);
    issue(2'b01, 0, 0);

    // Illegal command with S set.
    set_op(0, 32'd9, 32'd9, 4'b1111, 1'b1);
    issue(2'b01, 0, 0);
    chk("illegal_sr", {60'd0, sr}, 64'h6);

    // Flush in IDLE blocks acceptance.
    req0_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    @(negedge clk);
    #1;
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);
    req0_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Async reset in the middle of EXEC.
    set_op(0, 32'd1, 32'd1, 4'b0010, 1'b1);
    req0_valid = 1'b1; req0_first = op_a[0]; req0_second = op_b[0];
    req0_cmd = op_c[0]; req0_s = op_s[0];
    #1;
    chk("rstop_ready", {63'd0, req0_ready}, 64'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rstop_sr", {60'd0, sr}, 64'd0);
    chk("rstop_busy", {63'd0, busy}, 64'd0);
    chk("rstop_result", {32'd0, rsp_result}, 64'd0);
    chk("rstop_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    m_sr = 4'd0; m_last = 1;
    @(negedge clk);
    #1;
    chk("rstop_no_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 160; n++) begin
      for (int p = 0; p < 2; p++) begin
        op_a[p] = pick();
        op_b[p] = pick();
        r = $urandom_range(0, 9);
        op_c[p] = (r < 8) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
        op_s[p] = 1'($urandom_range(0, 1));
      end
      mask = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      fmode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      hold = $urandom_range(0, 3);
      issue(mask, fmode, hold);
    end

    @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
